// File: rtl/pixel_frame_buffer_if.sv
// Pixel write / raster readback bundle between the drawing engine side
// (master) and the frame store (slave).
interface pixel_frame_buffer_if;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [2:0]  iColour;
    logic        iPlot;
    logic        iReadStart;
    logic [7:0]  oRdX;
    logic [6:0]  oRdY;
    logic [2:0]  oRdColour;
    logic        oRdValid;
    logic        oRdDone;
    logic        oBusy;
    logic [14:0] oWriteCount;
    logic [7:0]  oDropCount;

    modport master (
        output iX, iY, iColour, iPlot, iReadStart,
        input  oRdX, oRdY, oRdColour, oRdValid, oRdDone, oBusy, oWriteCount, oDropCount
    );

    modport slave (
        input  iX, iY, iColour, iPlot, iReadStart,
        output oRdX, oRdY, oRdColour, oRdValid, oRdDone, oBusy, oWriteCount, oDropCount
    );
endinterface

// File: rtl/pixel_frame_buffer.sv
// On-chip 160x120x3 frame store: clears itself after reset, accepts plot
// strobes, and dumps the frame in raster order on request.
module pixel_frame_buffer #(
    parameter int unsigned X_SCREEN_PIXELS = 160,
    parameter int unsigned Y_SCREEN_PIXELS = 120
) (
    input  logic                 iClock,
    input  logic                 iResetn,
    pixel_frame_buffer_if.slave  bus
);
    localparam int unsigned NPIX      = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam logic [7:0]  X_LIM     = 8'(X_SCREEN_PIXELS);
    localparam logic [6:0]  Y_LIM     = 7'(Y_SCREEN_PIXELS);
    localparam logic [7:0]  LAST_X    = 8'(X_SCREEN_PIXELS - 1);
    localparam logic [6:0]  LAST_Y    = 7'(Y_SCREEN_PIXELS - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, READ} state_t;

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic        rd_issue;

    logic [2:0]  mem [NPIX];
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        plot_acc, plot_drop;

    logic        s1_vld_q;
    logic [7:0]  s1_x_q;
    logic [6:0]  s1_y_q;
    logic [2:0]  s1_col_q;

    logic        rd_vld_q, rd_done_q;
    logic [7:0]  rd_x_q;
    logic [6:0]  rd_y_q;
    logic [2:0]  rd_col_q;
    logic [14:0] wcnt_q;
    logic [7:0]  dcnt_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        x_d      = x_q;
        y_d      = y_q;
        rd_issue = 1'b0;
        case (state_q)
            CLEAR: begin
                addr_d = addr_q + 15'd1;
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            IDLE: begin
                if (bus.iReadStart) begin
                    state_d = READ;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            READ: begin
                rd_issue = 1'b1;
                addr_d   = addr_q + 15'd1;
                if (x_q == LAST_X) begin
                    x_d = '0;
                    y_d = y_q + 7'd1;
                end else begin
                    x_d = x_q + 8'd1;
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // CLEAR owns the single write port, so plots arriving then are dropped.
    always_comb begin
        plot_acc  = bus.iPlot && (bus.iX < X_LIM) && (bus.iY < Y_LIM) && (state_q != CLEAR);
        plot_drop = bus.iPlot && !plot_acc;
        wr_en     = iResetn && ((state_q == CLEAR) || plot_acc);
        wr_addr   = (state_q == CLEAR) ? addr_q
                  : 15'(bus.iY) * 15'(X_SCREEN_PIXELS) + 15'(bus.iX);
        wr_data   = (state_q == CLEAR) ? 3'd0 : bus.iColour;
    end

    always_ff @(posedge iClock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        s1_col_q <= mem[addr_q];
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q   <= CLEAR;
            addr_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_done_q <= 1'b0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            rd_col_q  <= '0;
            wcnt_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            x_q       <= x_d;
            y_q       <= y_d;
            s1_vld_q  <= rd_issue;
            s1_x_q    <= x_q;
            s1_y_q    <= y_q;
            rd_vld_q  <= s1_vld_q;
            if (s1_vld_q) begin
                rd_x_q   <= s1_x_q;
                rd_y_q   <= s1_y_q;
                rd_col_q <= s1_col_q;
            end
            rd_done_q <= rd_vld_q && (rd_x_q == LAST_X) && (rd_y_q == LAST_Y);
            if (plot_acc && (wcnt_q != '1)) begin
                wcnt_q <= wcnt_q + 15'd1;
            end
            if (plot_drop && (dcnt_q != '1)) begin
                dcnt_q <= dcnt_q + 8'd1;
            end
        end
    end

    assign bus.oRdX        = rd_x_q;
    assign bus.oRdY        = rd_y_q;
    assign bus.oRdColour   = rd_col_q;
    assign bus.oRdValid    = rd_vld_q;
    assign bus.oRdDone     = rd_done_q;
    assign bus.oBusy       = (state_q != IDLE);
    assign bus.oWriteCount = wcnt_q;
    assign bus.oDropCount  = dcnt_q;
endmodule

// File: doc/pixel_frame_buffer.md
# pixel_frame_buffer

Receiving end of the box-drawing pixel stream. Accepts the per-cycle plot strobe with X/Y/colour from the drawing engine and stores each pixel into an on-chip 160x120x3 frame store. A raster-order readback port lets the display or checker side dump the stored frame one pixel per cycle. After reset the block clears the whole frame store to black before accepting pixels.

## Interface
- X_SCREEN_PIXELS, 160, frame width in pixels (X width fixed at 8 bits)
- Y_SCREEN_PIXELS, 120, frame height in pixels (Y width fixed at 7 bits)
- iClock  in  1  single clock; all state changes on its rising edge
- iResetn  in  1  synchronous, active-low reset, sampled on rising edge of iClock
- iX  in  8  pixel X coordinate of incoming write
- iY  in  7  pixel Y coordinate of incoming write
- iColour  in  3  pixel colour of incoming write
- iPlot  in  1  write strobe; one pixel per cycle while high
- iReadStart  in  1  request a full-frame readback; sampled only in IDLE
- oRdX  out  8  X of pixel on oRdColour
- oRdY  out  7  Y of pixel on oRdColour
- oRdColour  out  3  stored colour read back
- oRdValid  out  1  oRdX/oRdY/oRdColour valid this cycle
- oRdDone  out  1  one-cycle pulse after last readback pixel
- oBusy  out  1  high in CLEAR and READ
- oWriteCount  out  15  accepted writes since reset; saturates at 32767
- oDropCount  out  8  rejected writes since reset; saturates at 255

## Operation
- Linear address = iY*X_SCREEN_PIXELS + iX, computed in 15 bits; frame store is 19200 words x 3 bits, dual-port (one write, one read), synchronous read.
- States: CLEAR, IDLE, READ.
- CLEAR: entered on reset. Writes colour 0 to addresses 0..19199, one per cycle. After address 19199 -> IDLE. oBusy=1.
- IDLE: iReadStart=1 -> READ (read address 0). Otherwise stay. oBusy=0.
- READ: issues read addresses 0..19199 in raster order (X fastest), one per cycle. After issuing 19199 -> IDLE. oBusy=1.
- iReadStart outside IDLE: ignored, no queuing.
- Pixel write, any state except CLEAR: iPlot=1 with iX<160 and iY<120 -> write iColour at address, oWriteCount+1.
- Rejected write: iPlot=1 with iX>=160 or iY>=120, or iPlot=1 during CLEAR -> no store update, oDropCount+1.
- Both counters saturate, never wrap.
- Writes during READ are legal. If a write and read hit the same address in the same cycle, the read returns the old value.

## Timing
- Reset values: oRdX=0, oRdY=0, oRdColour=0, oRdValid=0, oRdDone=0, oBusy=1 (CLEAR), oWriteCount=0, oDropCount=0.
- Reset mid-READ or mid-CLEAR aborts immediately and restarts CLEAR from address 0. Frame contents are re-cleared.
- CLEAR lasts exactly 19200 cycles. oBusy falls on the cycle IDLE is entered.
- Write latency: a pixel written on edge N is visible to a read addressed on edge N+1 or later.
- Read latency: 1 cycle. The read of address A is issued on edge N; oRdValid=1 with matching oRdX/oRdY/oRdColour after edge N+1.
- Readback emits 19200 consecutive oRdValid cycles. The first valid cycle is 2 edges after the iReadStart sample.
- oRdDone=1 for the single cycle immediately after the last oRdValid (X=159, Y=119). oRdValid=0 in that cycle.
- iReadStart sampled in the same cycle READ returns to IDLE is ignored. A new READ can start on the next IDLE cycle.
- Counters update on the edge that samples iPlot.

## Test plan
- Reset, wait for oBusy=0 -> exactly 19200 cycles. Readback returns 19200 pixels all colour 0, then one oRdDone pulse. Both counters = 0.
- Plot 4x4 box at (10,20), colour 3, 16 consecutive cycles. Then readback -> those 16 pixels read 3, all others 0. oWriteCount=16.
- Plot (160,5), (5,120) and (255,127) -> store unchanged, oDropCount=3, oWriteCount unchanged. Drive 300 bad plots -> oDropCount=255.
- Plot colour 5 during CLEAR -> pixel remains 0 on readback, oDropCount increments.
- Start readback. In the cycle address (0,1) is read, write (0,1) colour 7 -> that readback shows 0. A second readback shows 7.
- Assert iResetn=0 mid-readback -> oRdValid drops next cycle, oBusy=1. CLEAR restarts; after 19200 cycles all pixels are 0.
